// File: rtl/cmp_pkg.sv
// Shared definitions for the four-node CMP: ISA encodings, NIC address map,
// the packet layout and the core ALU.
package cmp_pkg;

    localparam int DATA_W = 64;
    localparam int NODES  = 4;
    localparam int NREG   = 32;

    localparam logic [5:0] OP_RTYPE = 6'b101010;
    localparam logic [5:0] OP_LD    = 6'b100000;
    localparam logic [5:0] OP_SD    = 6'b100001;
    localparam logic [5:0] OP_BEZ   = 6'b100010;
    localparam logic [5:0] OP_BNEZ  = 6'b100011;
    localparam logic [5:0] OP_NOP   = 6'b111100;

    localparam logic [5:0] FN_AND = 6'd1;
    localparam logic [5:0] FN_OR  = 6'd2;
    localparam logic [5:0] FN_XOR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4;
    localparam logic [5:0] FN_MOV = 6'd5;
    localparam logic [5:0] FN_ADD = 6'd6;
    localparam logic [5:0] FN_SUB = 6'd7;

    localparam logic [1:0] NIC_TAG      = 2'b11;
    localparam logic [1:0] NIC_IN_DATA  = 2'd0;
    localparam logic [1:0] NIC_IN_STAT  = 2'd1;
    localparam logic [1:0] NIC_OUT_DATA = 2'd2;
    localparam logic [1:0] NIC_OUT_STAT = 2'd3;

    localparam logic [31:0] HALT_INST = 32'h0000_0000;

    // The two MSBs of a packet name the destination node.
    typedef struct packed {
        logic [1:0]  dest;
        logic [61:0] payload;
    } pkt_t;

    function automatic logic [DATA_W-1:0] alu(input logic [5:0] fn,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        case (fn)
            FN_AND:  res = a & b;
            FN_OR:   res = a | b;
            FN_XOR:  res = a ^ b;
            FN_NOT:  res = ~a;
            FN_MOV:  res = a;
            FN_ADD:  res = a + b;
            FN_SUB:  res = a - b;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cardinal_cmp_if.sv
// Per-node memory port: instruction fetch plus data load/store.
interface cardinal_cmp_if;
    logic [31:0] inst_in;
    logic [63:0] d_in;
    logic [31:0] pc_out;
    logic [63:0] d_out;
    logic [31:0] addr_out;
    logic        memEn;
    logic        memWrEn;

    modport master (input inst_in, d_in, output pc_out, d_out, addr_out, memEn, memWrEn);
    modport slave  (output inst_in, d_in, input pc_out, d_out, addr_out, memEn, memWrEn);
endinterface

// File: rtl/cmp_core.sv
// Single-cycle 64-bit core with a one-entry NIC input and output buffer.
module cmp_core
    import cmp_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       inst_in,
    input  logic [DATA_W-1:0] d_in,
    output logic [31:0]       pc_out,
    output logic [DATA_W-1:0] d_out,
    output logic [31:0]       addr_out,
    output logic              memEn,
    output logic              memWrEn,
    output logic              out_full,
    output pkt_t              out_pkt,
    output logic              in_full,
    input  logic              deliver,
    input  pkt_t              deliver_pkt,
    input  logic              out_taken
);
    logic [DATA_W-1:0] regs [NREG];
    pkt_t              in_pkt;

    logic [5:0]  op, func;
    logic [4:0]  rd, ra, rb;
    logic [15:0] imm;
    logic        unused;

    assign op     = inst_in[31:26];
    assign rd     = inst_in[25:21];
    assign ra     = inst_in[20:16];
    assign rb     = inst_in[15:11];
    assign func   = inst_in[5:0];
    assign imm    = inst_in[15:0];
    assign unused = ^inst_in[10:6];

    logic is_r, is_ld, is_sd, is_bez, is_bnez;
    always_comb begin
        is_r = 1'b0; is_ld = 1'b0; is_sd = 1'b0; is_bez = 1'b0; is_bnez = 1'b0;
        case (op)
            OP_RTYPE: is_r    = 1'b1;
            OP_LD:    is_ld   = 1'b1;
            OP_SD:    is_sd   = 1'b1;
            OP_BEZ:   is_bez  = 1'b1;
            OP_BNEZ:  is_bnez = 1'b1;
            OP_NOP:   ;
            default:  ;
        endcase
    end

    logic              halt, is_nic, ld_stall, sd_stall, advance, nic_rd, nic_wr;
    logic              taken, r_ok, wr_en;
    logic [1:0]        nic_off;
    logic [DATA_W-1:0] rd_val, ld_data, wdata;

    assign halt    = (inst_in == HALT_INST);
    assign is_nic  = (imm[15:14] == NIC_TAG);
    assign nic_off = imm[1:0];
    assign rd_val  = regs[rd];

    // Stalls only ever come from the NIC; dmem is always ready.
    assign ld_stall = is_ld && is_nic && (nic_off == NIC_IN_DATA) && !in_full;
    assign sd_stall = is_sd && is_nic && (nic_off == NIC_OUT_DATA) && out_full;
    assign advance  = !RESET && !halt && !ld_stall && !sd_stall;
    assign nic_rd   = advance && is_ld && is_nic && (nic_off == NIC_IN_DATA);
    assign nic_wr   = advance && is_sd && is_nic && (nic_off == NIC_OUT_DATA);

    always_comb begin
        ld_data = d_in;
        if (is_nic) begin
            case (nic_off)
                NIC_IN_DATA:  ld_data = in_pkt;
                NIC_IN_STAT:  ld_data = {{(DATA_W-1){1'b0}}, in_full};
                NIC_OUT_STAT: ld_data = {{(DATA_W-1){1'b0}}, out_full};
                default:      ld_data = '0;
            endcase
        end
    end

    assign r_ok  = (func >= FN_AND) && (func <= FN_SUB);
    assign wr_en = advance && (is_ld || (is_r && r_ok));
    assign wdata = is_ld ? ld_data : alu(func, regs[ra], regs[rb]);
    assign taken = (is_bez && (rd_val == '0)) || (is_bnez && (rd_val != '0));

    assign memEn    = !RESET && (is_ld || is_sd) && !is_nic;
    assign memWrEn  = memEn && is_sd;
    assign addr_out = RESET ? 32'd0 : {16'd0, imm};
    assign d_out    = RESET ? '0 : rd_val;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_out   <= 32'd0;
            in_full  <= 1'b0;
            out_full <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (advance) pc_out <= taken ? {16'd0, imm} : pc_out + 32'd4;
            if (wr_en) regs[rd] <= wdata;
            if (nic_rd) in_full <= 1'b0;
            else if (deliver) in_full <= 1'b1;
            if (out_taken) out_full <= 1'b0;
            else if (nic_wr) out_full <= 1'b1;
        end
    end

    // Buffer payloads are qualified by the full flags and need no reset.
    always_ff @(posedge CLK) begin
        if (deliver) in_pkt <= deliver_pkt;
        if (nic_wr) out_pkt <= pkt_t'(rd_val);
    end

endmodule

// File: rtl/cardinal_cmp.sv
// Four-node CMP top: four cmp_core instances plus the packet crossbar.
// Define CMP_RR_ARB_EN for per-destination round-robin arbitration.
module cardinal_cmp
    import cmp_pkg::*;
(
    input logic            CLK,
    input logic            RESET,
    cardinal_cmp_if.master node0,
    cardinal_cmp_if.master node1,
    cardinal_cmp_if.master node2,
    cardinal_cmp_if.master node3
);
    logic       out_full    [NODES];
    pkt_t       out_pkt     [NODES];
    logic       in_full     [NODES];
    logic       deliver     [NODES];
    pkt_t       deliver_pkt [NODES];
    logic       out_taken   [NODES];
    logic       gnt_vld     [NODES];
    logic [1:0] gnt_src     [NODES];
    logic [1:0] start       [NODES];

    cmp_core u_node0 (
        .CLK(CLK), .RESET(RESET), .inst_in(node0.inst_in), .d_in(node0.d_in),
        .pc_out(node0.pc_out), .d_out(node0.d_out), .addr_out(node0.addr_out),
        .memEn(node0.memEn), .memWrEn(node0.memWrEn), .out_full(out_full[0]),
        .out_pkt(out_pkt[0]), .in_full(in_full[0]), .deliver(deliver[0]),
        .deliver_pkt(deliver_pkt[0]), .out_taken(out_taken[0])
    );
    cmp_core u_node1 (
        .CLK(CLK), .RESET(RESET), .inst_in(node1.inst_in), .d_in(node1.d_in),
        .pc_out(node1.pc_out), .d_out(node1.d_out), .addr_out(node1.addr_out),
        .memEn(node1.memEn), .memWrEn(node1.memWrEn), .out_full(out_full[1]),
        .out_pkt(out_pkt[1]), .in_full(in_full[1]), .deliver(deliver[1]),
        .deliver_pkt(deliver_pkt[1]), .out_taken(out_taken[1])
    );
    cmp_core u_node2 (
        .CLK(CLK), .RESET(RESET), .inst_in(node2.inst_in), .d_in(node2.d_in),
        .pc_out(node2.pc_out), .d_out(node2.d_out), .addr_out(node2.addr_out),
        .memEn(node2.memEn), .memWrEn(node2.memWrEn), .out_full(out_full[2]),
        .out_pkt(out_pkt[2]), .in_full(in_full[2]), .deliver(deliver[2]),
        .deliver_pkt(deliver_pkt[2]), .out_taken(out_taken[2])
    );
    cmp_core u_node3 (
        .CLK(CLK), .RESET(RESET), .inst_in(node3.inst_in), .d_in(node3.d_in),
        .pc_out(node3.pc_out), .d_out(node3.d_out), .addr_out(node3.addr_out),
        .memEn(node3.memEn), .memWrEn(node3.memWrEn), .out_full(out_full[3]),
        .out_pkt(out_pkt[3]), .in_full(in_full[3]), .deliver(deliver[3]),
        .deliver_pkt(deliver_pkt[3]), .out_taken(out_taken[3])
    );

`ifdef CMP_RR_ARB_EN
    logic [1:0] last [NODES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int d = 0; d < NODES; d++) last[d] <= 2'd0;
        end else begin
            for (int d = 0; d < NODES; d++)
                if (gnt_vld[d]) last[d] <= gnt_src[d];
        end
    end
`endif

    // Search starts just after the last winner (round-robin) or at node0 (fixed).
    always_comb begin
        for (int d = 0; d < NODES; d++) begin
`ifdef CMP_RR_ARB_EN
            start[d] = last[d] + 2'd1;
`else
            start[d] = 2'd0;
`endif
        end
    end

    // Registered in_full means a same-cycle read-clear still blocks delivery.
    always_comb begin
        for (int d = 0; d < NODES; d++) begin
            gnt_vld[d] = 1'b0;
            gnt_src[d] = 2'd0;
            for (int k = 0; k < NODES; k++) begin
                if (!gnt_vld[d] && !in_full[d] && out_full[2'(start[d] + k)] &&
                    (out_pkt[2'(start[d] + k)].dest == 2'(d))) begin
                    gnt_vld[d] = 1'b1;
                    gnt_src[d] = 2'(start[d] + k);
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NODES; s++) out_taken[s] = 1'b0;
        for (int d = 0; d < NODES; d++) begin
            deliver[d]     = gnt_vld[d];
            deliver_pkt[d] = out_pkt[gnt_src[d]];
            if (gnt_vld[d]) out_taken[gnt_src[d]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_cardinal_cmp.sv
// Directed self-checking bench for cardinal_cmp with per-node imem/dmem models.
module tb_cardinal_cmp;

    localparam logic [5:0] LD = 6'b100000, SD = 6'b100001, BEZ = 6'b100010, BNEZ = 6'b100011;
    localparam logic [5:0] F_AND = 6'd1, F_XOR = 6'd3, F_NOT = 6'd4, F_ADD = 6'd6, F_SUB = 6'd7;
    localparam logic [63:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    cardinal_cmp_if n0 ();
    cardinal_cmp_if n1 ();
    cardinal_cmp_if n2 ();
    cardinal_cmp_if n3 ();

    cardinal_cmp dut (.CLK(CLK), .RESET(RESET), .node0(n0), .node1(n1), .node2(n2), .node3(n3));

    logic [31:0] imem [4][512];
    logic [63:0] dmem [4][512];
    logic        pl_we = 1'b0;
    int          pl_n = 0;
    logic [8:0]  pl_a = '0;
    logic [63:0] pl_d = '0;
    int          checks = 0;
    int          errors = 0;

    assign n0.inst_in = imem[0][n0.pc_out[10:2]];
    assign n1.inst_in = imem[1][n1.pc_out[10:2]];
    assign n2.inst_in = imem[2][n2.pc_out[10:2]];
    assign n3.inst_in = imem[3][n3.pc_out[10:2]];
    assign n0.d_in = dmem[0][n0.addr_out[8:0]];
    assign n1.d_in = dmem[1][n1.addr_out[8:0]];
    assign n2.d_in = dmem[2][n2.addr_out[8:0]];
    assign n3.d_in = dmem[3][n3.addr_out[8:0]];

    always @(posedge CLK) begin
        if (pl_we) dmem[pl_n][pl_a] <= pl_d;
        if (n0.memWrEn) dmem[0][n0.addr_out[8:0]] <= n0.d_out;
        if (n1.memWrEn) dmem[1][n1.addr_out[8:0]] <= n1.d_out;
        if (n2.memWrEn) dmem[2][n2.addr_out[8:0]] <= n2.d_out;
        if (n3.memWrEn) dmem[3][n3.addr_out[8:0]] <= n3.d_out;
    end

    function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [4:0] rb);
        return {6'b101010, rd, ra, rb, 5'b0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [15:0] imm);
        return {op, rd, 5'b0, imm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic poke(input int n, input int a, input logic [63:0] d);
        pl_n = n; pl_a = a[8:0]; pl_d = d; pl_we = 1'b1;
        tick(1);
        pl_we = 1'b0;
    endtask

    task automatic begin_test();
        RESET = 1'b1;
        tick(1);
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 512; i++) imem[n][i] = 32'h0;
    endtask

    task automatic go();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        begin_test();
        imem[0][0] = i_op(LD, 5'd1, 16'h0000);
        imem[0][1] = i_op(LD, 5'd2, 16'h0001);
        imem[0][2] = r_op(F_ADD, 5'd3, 5'd1, 5'd2);
        imem[0][3] = i_op(SD, 5'd3, 16'h0002);
        poke(0, 0, 64'd5);
        poke(0, 1, 64'd7);
        poke(0, 2, 64'd0);
        tick(5);
        checks++; if (n0.pc_out !== 32'd0 || n0.memEn !== 1'b0) begin errors++; $display("FAIL reset_n0: pc=%h memEn=%b want pc=0 memEn=0", n0.pc_out, n0.memEn); end
        checks++; if (n1.pc_out !== 32'd0 || n1.memEn !== 1'b0) begin errors++; $display("FAIL reset_n1: pc=%h memEn=%b want pc=0 memEn=0", n1.pc_out, n1.memEn); end
        checks++; if (n2.pc_out !== 32'd0 || n2.memEn !== 1'b0) begin errors++; $display("FAIL reset_n2: pc=%h memEn=%b want pc=0 memEn=0", n2.pc_out, n2.memEn); end
        checks++; if (n3.pc_out !== 32'd0 || n3.memEn !== 1'b0) begin errors++; $display("FAIL reset_n3: pc=%h memEn=%b want pc=0 memEn=0", n3.pc_out, n3.memEn); end
    endtask

    task automatic test_basic();
        go();
        tick(12);
        checks++; if (dmem[0][2] !== 64'd12) begin errors++; $display("FAIL basic_sum: got %h want %h", dmem[0][2], 64'd12); end
        checks++; if (n0.pc_out !== 32'h10) begin errors++; $display("FAIL basic_halt_pc: got %h want %h", n0.pc_out, 32'h10); end
        checks++; if (n0.memEn !== 1'b0) begin errors++; $display("FAIL basic_halt_memen: got %b want 0", n0.memEn); end
    endtask

    task automatic test_overflow();
        begin_test();
        imem[0][0]  = i_op(LD, 5'd1, 16'h0000);
        imem[0][1]  = i_op(LD, 5'd2, 16'h0001);
        imem[0][2]  = i_op(LD, 5'd4, 16'h0002);
        imem[0][3]  = r_op(F_ADD, 5'd3, 5'd1, 5'd2);
        imem[0][4]  = i_op(SD, 5'd3, 16'h0004);
        imem[0][5]  = r_op(F_SUB, 5'd5, 5'd4, 5'd2);
        imem[0][6]  = i_op(SD, 5'd5, 16'h0005);
        imem[0][7]  = r_op(F_XOR, 5'd6, 5'd1, 5'd2);
        imem[0][8]  = i_op(SD, 5'd6, 16'h0006);
        imem[0][9]  = r_op(F_NOT, 5'd7, 5'd2, 5'd0);
        imem[0][10] = i_op(SD, 5'd7, 16'h0007);
        imem[0][11] = r_op(F_AND, 5'd8, 5'd1, 5'd2);
        imem[0][12] = i_op(SD, 5'd8, 16'h0008);
        poke(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        poke(0, 1, 64'd1);
        poke(0, 2, 64'd0);
        for (int a = 4; a <= 8; a++) poke(0, a, DEAD);
        go();
        tick(25);
        checks++; if (dmem[0][4] !== 64'd0) begin errors++; $display("FAIL add_wrap: got %h want %h", dmem[0][4], 64'd0); end
        checks++; if (dmem[0][5] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_wrap: got %h want %h", dmem[0][5], 64'hFFFF_FFFF_FFFF_FFFF); end
        checks++; if (dmem[0][6] !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL xor: got %h want %h", dmem[0][6], 64'hFFFF_FFFF_FFFF_FFFE); end
        checks++; if (dmem[0][7] !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL not: got %h want %h", dmem[0][7], 64'hFFFF_FFFF_FFFF_FFFE); end
        checks++; if (dmem[0][8] !== 64'd1) begin errors++; $display("FAIL and: got %h want %h", dmem[0][8], 64'd1); end
        checks++; if (n0.pc_out !== 32'h34) begin errors++; $display("FAIL alu_halt_pc: got %h want %h", n0.pc_out, 32'h34); end
    endtask

    task automatic test_loop();
        begin_test();
        imem[0][0] = i_op(LD, 5'd1, 16'h0000);
        imem[0][1] = i_op(LD, 5'd2, 16'h0001);
        imem[0][2] = i_op(LD, 5'd3, 16'h0003);
        imem[0][3] = r_op(F_ADD, 5'd3, 5'd3, 5'd2);
        imem[0][4] = r_op(F_SUB, 5'd1, 5'd1, 5'd2);
        imem[0][5] = i_op(BNEZ, 5'd1, 16'h000C);
        imem[0][6] = i_op(SD, 5'd3, 16'h0004);
        imem[0][7] = i_op(BEZ, 5'd1, 16'h0024);
        imem[0][8] = i_op(SD, 5'd2, 16'h0005);
        poke(0, 0, 64'd3);
        poke(0, 1, 64'd1);
        poke(0, 3, 64'd0);
        poke(0, 4, DEAD);
        poke(0, 5, 64'h55);
        go();
        tick(30);
        checks++; if (dmem[0][4] !== 64'd3) begin errors++; $display("FAIL loop_count: got %h want %h", dmem[0][4], 64'd3); end
        checks++; if (dmem[0][5] !== 64'h55) begin errors++; $display("FAIL bez_skip: got %h want %h", dmem[0][5], 64'h55); end
        checks++; if (n0.pc_out !== 32'h24) begin errors++; $display("FAIL loop_halt_pc: got %h want %h", n0.pc_out, 32'h24); end
    endtask

    task automatic test_nic();
        begin_test();
        imem[1][0] = i_op(LD, 5'd1, 16'h0000);
        imem[1][1] = i_op(SD, 5'd1, 16'hC002);
        imem[2][0] = i_op(LD, 5'd1, 16'hC001);
        imem[2][1] = i_op(BEZ, 5'd1, 16'h0000);
        imem[2][2] = i_op(LD, 5'd2, 16'hC000);
        imem[2][3] = i_op(LD, 5'd3, 16'hC001);
        imem[2][4] = i_op(SD, 5'd1, 16'h0000);
        imem[2][5] = i_op(SD, 5'd2, 16'h0001);
        imem[2][6] = i_op(SD, 5'd3, 16'h0002);
        poke(1, 0, 64'h8000_0000_0000_00AA);
        for (int a = 0; a < 3; a++) poke(2, a, DEAD);
        go();
        tick(30);
        checks++; if (dmem[2][0] !== 64'd1) begin errors++; $display("FAIL nic_status_before: got %h want %h", dmem[2][0], 64'd1); end
        checks++; if (dmem[2][1] !== 64'h8000_0000_0000_00AA) begin errors++; $display("FAIL nic_data: got %h want %h", dmem[2][1], 64'h8000_0000_0000_00AA); end
        checks++; if (dmem[2][2] !== 64'd0) begin errors++; $display("FAIL nic_status_after: got %h want %h", dmem[2][2], 64'd0); end
        checks++; if (n2.pc_out !== 32'h1C || n1.pc_out !== 32'h8) begin errors++; $display("FAIL nic_halt_pcs: n1=%h n2=%h want n1=8 n2=1c", n1.pc_out, n2.pc_out); end
    endtask

    task automatic test_self_latency();
        begin_test();
        imem[0][0] = i_op(LD, 5'd1, 16'h0000);
        imem[0][1] = i_op(SD, 5'd1, 16'hC002);
        imem[0][2] = i_op(LD, 5'd2, 16'hC000);
        imem[0][3] = i_op(SD, 5'd2, 16'h0001);
        poke(0, 0, 64'h0000_0000_0000_0033);
        poke(0, 1, DEAD);
        go();
        tick(3);
        checks++; if (n0.pc_out !== 32'h8 || n0.memEn !== 1'b0) begin errors++; $display("FAIL self_stall: pc=%h memEn=%b want pc=8 memEn=0", n0.pc_out, n0.memEn); end
        tick(1);
        checks++; if (n0.pc_out !== 32'hC) begin errors++; $display("FAIL self_latency: got pc %h want %h", n0.pc_out, 32'hC); end
        tick(5);
        checks++; if (dmem[0][1] !== 64'h33) begin errors++; $display("FAIL self_data: got %h want %h", dmem[0][1], 64'h33); end
    endtask

    task automatic test_contention();
        logic [63:0] exp [4];
`ifdef CMP_RR_ARB_EN
        exp[0] = 64'hC000_0000_0000_00B0; exp[1] = 64'hC000_0000_0000_00A0;
        exp[2] = 64'hC000_0000_0000_00B1; exp[3] = 64'hC000_0000_0000_00A1;
`else
        exp[0] = 64'hC000_0000_0000_00A0; exp[1] = 64'hC000_0000_0000_00A1;
        exp[2] = 64'hC000_0000_0000_00B0; exp[3] = 64'hC000_0000_0000_00B1;
`endif
        begin_test();
        for (int n = 0; n < 2; n++) begin
            imem[n][0] = i_op(LD, 5'd1, 16'h0000);
            imem[n][1] = i_op(LD, 5'd2, 16'h0001);
            imem[n][2] = i_op(SD, 5'd1, 16'hC002);
            imem[n][3] = i_op(SD, 5'd2, 16'hC002);
        end
        for (int i = 0; i < 4; i++) begin
            imem[3][i]     = i_op(LD, 5'(i + 1), 16'hC000);
            imem[3][i + 4] = i_op(SD, 5'(i + 1), 16'(i));
        end
        poke(0, 0, 64'hC000_0000_0000_00A0);
        poke(0, 1, 64'hC000_0000_0000_00A1);
        poke(1, 0, 64'hC000_0000_0000_00B0);
        poke(1, 1, 64'hC000_0000_0000_00B1);
        for (int a = 0; a < 4; a++) poke(3, a, DEAD);
        go();
        tick(5);
`ifdef CMP_RR_ARB_EN
        checks++; if (n0.pc_out !== 32'hC || n1.pc_out !== 32'h10) begin errors++; $display("FAIL contend_stall: n0=%h n1=%h want n0=c n1=10", n0.pc_out, n1.pc_out); end
`else
        checks++; if (n0.pc_out !== 32'h10 || n1.pc_out !== 32'hC) begin errors++; $display("FAIL contend_stall: n0=%h n1=%h want n0=10 n1=c", n0.pc_out, n1.pc_out); end
`endif
        tick(25);
        for (int i = 0; i < 4; i++) begin
            checks++; if (dmem[3][i] !== exp[i]) begin errors++; $display("FAIL contend_order[%0d]: got %h want %h", i, dmem[3][i], exp[i]); end
        end
        checks++; if (n3.pc_out !== 32'h20) begin errors++; $display("FAIL contend_halt_pc: got %h want %h", n3.pc_out, 32'h20); end
    endtask

    task automatic test_stall_reset();
        begin_test();
        imem[0][0] = i_op(LD, 5'd1, 16'h0000);
        imem[0][1] = i_op(SD, 5'd1, 16'hC002);
        imem[0][2] = i_op(SD, 5'd1, 16'hC002);
        imem[2][0] = i_op(LD, 5'd1, 16'hC000);
        poke(0, 0, 64'hC000_0000_0000_0077);
        go();
        tick(8);
        checks++; if (n2.pc_out !== 32'd0 || n2.memEn !== 1'b0 || n2.addr_out !== 32'hC000) begin errors++; $display("FAIL empty_stall: pc=%h memEn=%b addr=%h want 0/0/c000", n2.pc_out, n2.memEn, n2.addr_out); end
        checks++; if (n0.pc_out !== 32'hC) begin errors++; $display("FAIL blocked_sender: got pc %h want %h", n0.pc_out, 32'hC); end
        RESET = 1'b1;
        tick(1);
        checks++; if (n2.pc_out !== 32'd0 || n2.addr_out !== 32'd0 || n2.d_out !== 64'd0 || n2.memEn !== 1'b0 || n2.memWrEn !== 1'b0) begin errors++; $display("FAIL midreset_n2: pc=%h addr=%h d=%h en=%b wr=%b want all 0", n2.pc_out, n2.addr_out, n2.d_out, n2.memEn, n2.memWrEn); end
        checks++; if (n0.pc_out !== 32'd0 || n0.memEn !== 1'b0 || n0.addr_out !== 32'd0) begin errors++; $display("FAIL midreset_n0: pc=%h en=%b addr=%h want all 0", n0.pc_out, n0.memEn, n0.addr_out); end
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 512; i++) imem[n][i] = 32'h0;
        imem[0][0] = i_op(LD, 5'd2, 16'hC003);
        imem[0][1] = i_op(SD, 5'd2, 16'h0004);
        imem[0][2] = i_op(SD, 5'd1, 16'h0003);
        imem[3][0] = i_op(LD, 5'd1, 16'hC001);
        imem[3][1] = i_op(SD, 5'd1, 16'h0000);
        poke(0, 3, DEAD);
        poke(0, 4, DEAD);
        poke(3, 0, DEAD);
        go();
        tick(10);
        checks++; if (dmem[0][4] !== 64'd0) begin errors++; $display("FAIL reset_out_empty: got %h want %h", dmem[0][4], 64'd0); end
        checks++; if (dmem[0][3] !== 64'd0) begin errors++; $display("FAIL reset_regs_zero: got %h want %h", dmem[0][3], 64'd0); end
        checks++; if (dmem[3][0] !== 64'd0) begin errors++; $display("FAIL reset_in_empty: got %h want %h", dmem[3][0], 64'd0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_loop();
        test_nic();
        test_self_latency();
        test_contention();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
